// File: rtl/clk_div_ratio_ctrl_pkg.sv
// Shared definitions for the clock-divider ratio controller: state encoding,
// default bus width and counter sizing helpers.
package clk_div_pkg;

  localparam int DIV_RATIO_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    IDLE      = 3'd1,
    WAIT_EDGE = 3'd2,
    APPLY     = 3'd3,
    SETTLE    = 3'd4,
    ACK       = 3'd5
  } state_t;

  // Longest wait for a divided-clock rising edge before forcing the change.
  function automatic int timeout_cycles(input int ratio_w);
    return 1 << (ratio_w + 1);
  endfunction

  // One counter serves both the edge timeout and the settle period.
  function automatic int cnt_width(input int ratio_w, input int settle);
    int a;
    int b;
    a = ratio_w + 2;
    b = $clog2(settle + 1);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_div_ratio_ctrl_if.sv
// Ratio configuration request channel: valid/ready handshake plus reject pulse.
interface clk_div_ratio_ctrl_if
  import clk_div_pkg::*;
#(
  parameter int DIV_RATIO_WIDTH = DIV_RATIO_WIDTH_DEF
);

  logic                       cfg_valid;
  logic [DIV_RATIO_WIDTH-1:0] cfg_ratio;
  logic                       cfg_ready;
  logic                       cfg_err;

  modport master (
    output cfg_valid,
    output cfg_ratio,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ratio,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clk_div_ratio_ctrl_rise_edge_det.sv
// Rising-edge detector on a signal already synchronous to ref_clk.
module rise_edge_det (
  input  logic ref_clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise_pulse
);

  logic prev;

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= sig_in;
    end
  end

  assign rise_pulse = sig_in & ~prev;

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Control stage for the clock divider: accepts ratio requests, applies them right
// after a divided-clock rising edge and flags when the divided clock has settled.
module clk_div_ratio_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_RATIO_WIDTH = DIV_RATIO_WIDTH_DEF,
  parameter int DEFAULT_RATIO   = 2,
  parameter int SETTLE_CYCLES   = 8
) (
  input  logic                       ref_clk,
  input  logic                       reset,
  clk_div_ratio_ctrl_if.slave        cfg,
  input  logic                       div_clk_in,
  output logic [DIV_RATIO_WIDTH-1:0] division_ratio,
  output logic                       enable,
  output logic                       clk_stable
);

  localparam int                       CNT_W        = cnt_width(DIV_RATIO_WIDTH, SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]         TIMEOUT_LAST = CNT_W'(timeout_cycles(DIV_RATIO_WIDTH) - 1);
  localparam logic [CNT_W-1:0]         SETTLE_LAST  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]         CNT_MAX      = '1;
  localparam logic [DIV_RATIO_WIDTH-1:0] RATIO_RST  = DIV_RATIO_WIDTH'(DEFAULT_RATIO);

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [DIV_RATIO_WIDTH-1:0]   pending;
  logic                         ready;
  logic                         err;
  logic                         rise;

  rise_edge_det u_rise (
    .ref_clk    (ref_clk),
    .reset      (reset),
    .sig_in     (div_clk_in),
    .rise_pulse (rise)
  );

  assign cfg.cfg_ready = ready;
  assign cfg.cfg_err   = err;

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      state          <= INIT;
      cnt            <= '0;
      pending        <= RATIO_RST;
      division_ratio <= RATIO_RST;
      enable         <= 1'b0;
      ready          <= 1'b0;
      err            <= 1'b0;
      clk_stable     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end

      unique case (state)
        INIT: begin
          enable <= 1'b1;
          cnt    <= '0;
          state  <= SETTLE;
        end

        IDLE: begin
          if (cfg.cfg_valid && ready) begin
            if (cfg.cfg_ratio == '0) begin
              err <= 1'b1;
            end else if (cfg.cfg_ratio == division_ratio) begin
              ready <= 1'b0;
              state <= ACK;
            end else begin
              pending    <= cfg.cfg_ratio;
              ready      <= 1'b0;
              clk_stable <= 1'b0;
              cnt        <= '0;
              state      <= WAIT_EDGE;
            end
          end
        end

        // A stuck divider never produces an edge; the timeout forces progress.
        WAIT_EDGE: begin
          if (rise || (cnt == TIMEOUT_LAST)) begin
            state <= APPLY;
          end
        end

        APPLY: begin
          enable         <= 1'b0;
          division_ratio <= pending;
          cnt            <= '0;
          state          <= SETTLE;
        end

        SETTLE: begin
          enable <= 1'b1;
          if (cnt == SETTLE_LAST) begin
            clk_stable <= 1'b1;
            ready      <= 1'b1;
            state      <= IDLE;
          end
        end

        ACK: begin
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          enable <= 1'b0;
          ready  <= 1'b0;
          state  <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Directed bench for clk_div_ratio_ctrl with a behavioural divider in the loop.
module tb_clk_div_ratio_ctrl;

  logic       ref_clk;
  logic       reset;
  logic       div_clk_in;
  logic [3:0] division_ratio;
  logic       enable;
  logic       clk_stable;
  logic       stuck;
  logic [3:0] dcnt;

  int n_chk  = 0;
  int n_fail = 0;

  clk_div_ratio_ctrl_if #(.DIV_RATIO_WIDTH(4)) cfg_bus ();

  clk_div_ratio_ctrl #(
    .DIV_RATIO_WIDTH (4),
    .DEFAULT_RATIO   (2),
    .SETTLE_CYCLES   (8)
  ) dut (
    .ref_clk        (ref_clk),
    .reset          (reset),
    .cfg            (cfg_bus),
    .div_clk_in     (div_clk_in),
    .division_ratio (division_ratio),
    .enable         (enable),
    .clk_stable     (clk_stable)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  // Divider model: one-cycle-high pulse every division_ratio cycles.
  always @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      dcnt       <= '0;
      div_clk_in <= 1'b0;
    end else if (!enable || stuck) begin
      dcnt       <= '0;
      div_clk_in <= 1'b0;
    end else begin
      div_clk_in <= (dcnt == 4'd0);
      dcnt       <= ((int'(dcnt) + 1) >= int'(division_ratio)) ? 4'd0 : dcnt + 4'd1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ref_clk);
    @(negedge ref_clk);
  endtask

  task automatic send(input logic [3:0] ratio);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ratio = ratio;
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_stable(input int start, output int cycles);
    cycles = start;
    while (!clk_stable && cycles < 60) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n;
    logic prev_s;
    logic got_rise;
    logic bad;

    reset             = 1'b1;
    stuck             = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_ratio = '0;
    repeat (2) @(negedge ref_clk);

    // 1: reset state and initial settle
    check_val("rst_ratio",  division_ratio, 2);
    check_val("rst_enable", enable, 0);
    check_val("rst_ready",  cfg_bus.cfg_ready, 0);
    check_val("rst_err",    cfg_bus.cfg_err, 0);
    check_val("rst_stable", clk_stable, 0);
    reset = 1'b0;
    check_val("t1_enable_first", enable, 0);
    tick();
    check_val("t1_enable_on", enable, 1);
    wait_stable(0, n);
    check_val("t1_settle_cycles", n, 9);
    check_val("t1_ready", cfg_bus.cfg_ready, 1);

    // 2: change 2 -> 4 aligned to a divided-clock rise
    prev_s = div_clk_in;
    send(4'd4);
    check_val("t2_ready_drop", cfg_bus.cfg_ready, 0);
    check_val("t2_stable_drop", clk_stable, 0);
    got_rise = div_clk_in && !prev_s;
    n = 0;
    while (!got_rise && n < 20) begin
      prev_s = div_clk_in;
      tick();
      got_rise = div_clk_in && !prev_s;
      n++;
    end
    check_val("t2_rise_seen", got_rise, 1);
    tick();
    check_val("t2_ratio_rise1", division_ratio, 2);
    check_val("t2_enable_rise1", enable, 1);
    tick();
    check_val("t2_ratio_rise2", division_ratio, 4);
    check_val("t2_enable_dip", enable, 0);
    tick();
    check_val("t2_enable_back", enable, 1);
    check_val("t2_stable_low", clk_stable, 0);
    wait_stable(1, n);
    check_val("t2_settle_cycles", n, 9);
    check_val("t2_ready_back", cfg_bus.cfg_ready, 1);

    // 3: zero ratio is rejected
    send(4'd0);
    check_val("t3_err", cfg_bus.cfg_err, 1);
    check_val("t3_ratio", division_ratio, 4);
    check_val("t3_stable", clk_stable, 1);
    check_val("t3_ready", cfg_bus.cfg_ready, 1);
    tick();
    check_val("t3_err_clear", cfg_bus.cfg_err, 0);

    // 4: same ratio is acknowledged without a change
    send(4'd4);
    check_val("t4_ready_low", cfg_bus.cfg_ready, 0);
    check_val("t4_stable", clk_stable, 1);
    check_val("t4_enable", enable, 1);
    tick();
    check_val("t4_ready_back", cfg_bus.cfg_ready, 1);
    check_val("t4_enable_after", enable, 1);
    check_val("t4_ratio", division_ratio, 4);

    // 5: stuck divider forces the timeout path
    stuck = 1'b1;
    repeat (2) tick();
    send(4'd6);
    n = 0;
    while (division_ratio != 4'd6 && n < 60) begin
      tick();
      n++;
    end
    check_val("t5_timeout_cycles", n, 33);
    check_val("t5_enable_dip", enable, 0);
    tick();
    check_val("t5_enable_back", enable, 1);
    wait_stable(1, n);
    check_val("t5_settle_cycles", n, 9);

    // 6a: reset while settling after a change to 8
    stuck = 1'b0;
    repeat (4) tick();
    send(4'd8);
    n = 0;
    while (enable && n < 40) begin
      tick();
      n++;
    end
    check_val("t6_apply_seen", enable, 0);
    check_val("t6_ratio_8", division_ratio, 8);
    tick();
    check_val("t6_in_settle", clk_stable, 0);
    reset = 1'b1;
    #1;
    check_val("t6_rst_ratio",  division_ratio, 2);
    check_val("t6_rst_enable", enable, 0);
    check_val("t6_rst_stable", clk_stable, 0);
    check_val("t6_rst_ready",  cfg_bus.cfg_ready, 0);
    repeat (2) tick();
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (division_ratio != 4'd2) bad = 1'b1;
    end
    check_val("t6_ratio_held", bad, 0);
    check_val("t6_stable_again", clk_stable, 1);

    // 6b: reset while a change is pending discards it
    stuck = 1'b1;
    repeat (2) tick();
    send(4'd8);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stuck = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (division_ratio != 4'd2) bad = 1'b1;
    end
    check_val("t6_pending_dropped", bad, 0);
    check_val("t6_final_ready", cfg_bus.cfg_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_ratio_ctrl.md
Name: clk_div_ratio_ctrl

Overview:
Upstream control stage for the clock divider. It accepts division-ratio configuration requests over a valid/ready handshake and drives the divider's division_ratio and enable inputs. A new ratio is applied only just after a rising edge of the divided clock, so the divider output never glitches. After each change it reports when the divided clock is stable.

Parameters:
DIV_RATIO_WIDTH, 4, width of the division ratio bus; matches the divider.
DEFAULT_RATIO, 2, ratio loaded at reset.
SETTLE_CYCLES, 8, number of ref_clk cycles after a ratio change before clk_stable asserts; must be at least 1.

Ports:
ref_clk  input  1  single clock; the same clock that drives the divider.
reset  input  1  asynchronous, active-high reset.
cfg_valid  input  1  configuration request valid.
cfg_ratio  input  DIV_RATIO_WIDTH  requested ratio.
cfg_ready  output  1  controller can accept a request.
cfg_err  output  1  one-cycle pulse when a request is rejected.
div_clk_in  input  1  divider output (divided_clk), fed back; generated from ref_clk flops.
division_ratio  output  DIV_RATIO_WIDTH  drives the divider's division_ratio input.
enable  output  1  drives the divider's enable input.
clk_stable  output  1  divided clock is settled at the current ratio.

Behaviour:
- One clock, ref_clk, rising edge. reset is asynchronous and active-high.
- All outputs are registered.
- Reset values:
  - division_ratio = DEFAULT_RATIO
  - enable = 0
  - cfg_ready = 0
  - cfg_err = 0
  - clk_stable = 0
  - state = INIT
- Edge detect: div_prev <= div_clk_in every cycle. rise = div_clk_in & ~div_prev.
- Handshake:
  - A request is accepted on a ref_clk edge where cfg_valid and cfg_ready are both 1.
  - cfg_ready is 1 only in IDLE.
  - cfg_valid while cfg_ready = 0 is ignored; the requester holds the request.
- States:
  - INIT: enable = 0. Moves to SETTLE on the next cycle, with enable <= 1 and the counter cleared.
  - IDLE: cfg_ready = 1. On an accepted request:
    - cfg_ratio == 0: pulse cfg_err for 1 cycle. Stay in IDLE. division_ratio is unchanged and clk_stable is unchanged.
    - cfg_ratio == division_ratio: no change. Go to ACK. clk_stable stays 1.
    - otherwise: latch the pending ratio and go to WAIT_EDGE. clk_stable <= 0.
  - WAIT_EDGE: wait for rise, or for a timeout of 2^(DIV_RATIO_WIDTH+1) cycles. Either one moves to APPLY.
  - APPLY (1 cycle): enable <= 0 and division_ratio <= pending ratio. Then go to SETTLE.
  - SETTLE: enable <= 1. The counter counts up to SETTLE_CYCLES. Then clk_stable <= 1 and go to IDLE.
  - ACK (1 cycle): cfg_ready = 0, then return to IDLE.
- Ratio 1 is legal; the divider treats it as bypass.
- Latency:
  - Accept to division_ratio update = (cycles waiting for rise) + 2.
  - Update to clk_stable = SETTLE_CYCLES + 1 cycles.
- Reset mid-operation (any state): all registers return to reset values immediately. Any pending ratio is discarded.
- cfg_err is never asserted outside IDLE.
- The timeout counter is the same width as the settle counter. Size it at max(DIV_RATIO_WIDTH+2, clog2(SETTLE_CYCLES+1)) bits, saturating.

Decomposition:
- Package clk_div_pkg holds:
  - the state encoding: INIT, IDLE, WAIT_EDGE, APPLY, SETTLE, ACK (3-bit localparams)
  - the default DIV_RATIO_WIDTH
  - the timeout constant function
- One sub-module, rise_edge_det: a 1-bit registered rising-edge detector with ports ref_clk, reset, sig_in, rise_pulse.

Test Plan:
1. Reset, then release with W=4, DEFAULT_RATIO=2 and a divider model attached.
   - enable = 0 for the first cycle, then 1.
   - clk_stable rises 9 cycles after enable rises.
   - cfg_ready = 1.
2. Request ratio 4 while the divider runs at 2.
   - cfg_ready drops the cycle after acceptance.
   - division_ratio changes to 4 exactly 2 cycles after the next div_clk_in rise.
   - enable is low for exactly that 1 cycle.
   - clk_stable is 0 until SETTLE completes.
3. Request ratio 0.
   - cfg_err high for exactly 1 cycle.
   - division_ratio stays 4; clk_stable stays 1; cfg_ready stays 1.
4. Request ratio 4 while already at 4.
   - cfg_ready low for 1 cycle; clk_stable stays 1; no enable dip.
5. Hold div_clk_in at 0 (stuck divider) and request ratio 6.
   - APPLY occurs after 32 cycles in WAIT_EDGE; division_ratio = 6.
6. Assert reset during SETTLE after a request for ratio 8.
   - Outputs immediately return to DEFAULT_RATIO=2, enable=0, clk_stable=0.
   - The pending ratio 8 is never applied.
